mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arb.sv | 149 ++++++++++++++
 tb/tb_mem_arb.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory arbiter: default widths, FSM state
// encoding and the one-hot pick codes used between the top and the picker.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } arb_state_e;

  // One-hot pick: bit 0 = fetch requester, bit 1 = data requester.
  localparam logic [1:0] PICK_NONE = 2'b00;
  localparam logic [1:0] PICK_IF   = 2'b01;
  localparam logic [1:0] PICK_D    = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational arbitration between the fetch and data requesters.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on conflict); without it
// the data requester always wins a conflict and last_winner is ignored.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       last_winner,  // 1 = data was granted most recently
  output logic [1:0] pick
);

`ifndef MEM_ARB_RR_EN
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
`endif

  // Choose at most one requester; conflicts resolved by priority policy.
  always_comb begin
    pick = PICK_NONE;
    if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      pick = last_winner ? PICK_IF : PICK_D;
`else
      pick = PICK_D;
`endif
    end else if (d_req) begin
      pick = PICK_D;
    end else if (if_req) begin
      pick = PICK_IF;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Shares one single-port memory between an instruction-fetch requester and a
// data requester. Optional feature macro: MEM_ARB_RR_EN (round-robin conflict
// priority with a last-winner flag); default build uses fixed data priority.
//
// Handshake: a requester holds req and its payload until it sees gnt; gnt is a
// one-cycle combinational pulse in an arbitration cycle (IDLE, or the
// completion cycle of the current access). The access then runs in the
// owner's ACC state with mem_ce=1 until mem_ready=1, and on that cycle the
// owner's rvalid pulses for one cycle with rdata (0 for a store).
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // debug
  output arb_state_e        dbg_state
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        pick;
  logic              last_winner;
  logic              arb_point;
  logic              complete;

  // An arbitration opportunity exists when idle or when the current access
  // finishes this cycle; reset suppresses any grant.
  assign arb_point = !rst && ((state_q == IDLE) || mem_ready);
  assign complete  = !rst && (state_q != IDLE) && mem_ready;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  // Remember which requester was granted most recently (resets to fetch).
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (d_gnt) begin
      last_d_q <= 1'b1;
    end else if (if_gnt) begin
      last_d_q <= 1'b0;
    end
  end

  assign last_winner = last_d_q;
`else
  assign last_winner = 1'b0;
`endif

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .last_winner (last_winner),
    .pick        (pick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: re-arbitrate when idle or on completion, else keep waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, IF_ACC, D_ACC: begin
        if ((state_q == IDLE) || mem_ready) begin
          if (pick[1]) begin
            state_d = D_ACC;
          end else if (pick[0]) begin
            state_d = IF_ACC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner's payload at the grant edge; clear it when going idle
  // so mem_we and the address bus read 0 outside an access.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (d_gnt) begin
      addr_q  <= d_addr;
      we_q    <= d_we;
      wdata_q <= d_wdata;
    end else if (if_gnt) begin
      addr_q  <= if_addr;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (arb_point) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end
  end

  // Grants, completion strobes and returned data.
  always_comb begin
    if_gnt    = arb_point && pick[0];
    d_gnt     = arb_point && pick[1];
    if_rvalid = complete && (state_q == IF_ACC);
    d_rvalid  = complete && (state_q == D_ACC);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
  end

  assign mem_ce    = !rst && (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus a randomized run
// checked against a transaction-level model of the shared memory port.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  arb_state_e    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  logic          mem_auto;
  logic [DW-1:0] mem_rdata_man;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // Memory model: content is a fixed function of the address presented.
  always_comb mem_rdata = mem_auto ? mem_fn(mem_addr) : mem_rdata_man;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state(dbg_state)
  );

  // Clock and overall time bound.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    mem_ready = 1'b1;
    rst = 1'b1;
    step();
    if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_addr = 32'h88;
    step();
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b want 00", {if_gnt, d_gnt});
    end
    checks++;
    if ({mem_ce, mem_we, if_rvalid, d_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctl: got %b want 0000", {mem_ce, mem_we, if_rvalid, d_rvalid});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: addr %h wdata %h ifr %h dr %h want 0", mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (mem_ce !== 1'b0) begin
      errors++; $display("FAIL reset_idle_ce: got %b want 0", mem_ce);
    end
    step();
  endtask

  task automatic test_solo_fetch();
    do_reset();
    mem_auto = 1'b0; mem_rdata_man = 32'h00500093; mem_ready = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      errors++; $display("FAIL solo_gnt: got %b want 10", {if_gnt, d_gnt});
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_ce, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL solo_mem: ce %b we %b addr %h want 1 0 100", mem_ce, mem_we, mem_addr);
    end
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h00500093}) begin
      errors++; $display("FAIL solo_rdata: rvalid %b rdata %h want 1 00500093", if_rvalid, if_rdata);
    end
    checks++;
    if ({d_rvalid, d_rdata} !== '0) begin
      errors++; $display("FAIL solo_nonowner: d_rvalid %b d_rdata %h want 0 0", d_rvalid, d_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({mem_ce, if_rvalid} !== 2'b00) begin
      errors++; $display("FAIL solo_after: ce %b rvalid %b want 00", mem_ce, if_rvalid);
    end
    mem_auto = 1'b1;
    step();
  endtask

  task automatic test_conflict();
    do_reset();
    mem_auto = 1'b1; mem_ready = 1'b1;
    // prior data access makes data the most recent winner
    d_req = 1'b1; d_addr = 32'h30;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL conf_pre_gnt: got %b want 1", d_gnt);
    end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, mem_fn(32'h30)}) begin
      errors++; $display("FAIL conf_pre_rdata: got %b %h want 1 %h", d_rvalid, d_rdata, mem_fn(32'h30));
    end
    step();
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h20;
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    checks++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      errors++; $display("FAIL conf_first: got %b want 10", {if_gnt, d_gnt});
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata, d_gnt, if_gnt} !== {1'b1, mem_fn(32'h200), 2'b10}) begin
      errors++; $display("FAIL conf_second: rvalid %b rdata %h d_gnt %b if_gnt %b", if_rvalid, if_rdata, d_gnt, if_gnt);
    end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_rdata, mem_addr} !== {1'b1, mem_fn(32'h20), 32'h20}) begin
      errors++; $display("FAIL conf_last: d_rvalid %b d_rdata %h addr %h", d_rvalid, d_rdata, mem_addr);
    end
`else
    checks++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      errors++; $display("FAIL conf_first: got %b want 01", {if_gnt, d_gnt});
    end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_rdata, mem_addr, if_gnt, d_gnt} !== {1'b1, mem_fn(32'h20), 32'h20, 2'b10}) begin
      errors++; $display("FAIL conf_second: d_rvalid %b d_rdata %h addr %h if_gnt %b d_gnt %b", d_rvalid, d_rdata, mem_addr, if_gnt, d_gnt);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata, mem_addr} !== {1'b1, mem_fn(32'h200), 32'h200}) begin
      errors++; $display("FAIL conf_last: rvalid %b rdata %h addr %h", if_rvalid, if_rdata, mem_addr);
    end
`endif
    step();
  endtask

  task automatic test_wait_states();
    do_reset();
    mem_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL wait_gnt: got %b want 1", d_gnt);
    end
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      @(negedge clk);
      checks++;
      if ({mem_ce, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'hDEADBEEF}) begin
        errors++; $display("FAIL wait_mem[%0d]: ce %b we %b addr %h wdata %h", i, mem_ce, mem_we, mem_addr, mem_wdata);
      end
      checks++;
      if ({d_rvalid, d_rdata} !== {(i == 3), 32'h0}) begin
        errors++; $display("FAIL wait_rvalid[%0d]: got %b %h want %b 0", i, d_rvalid, d_rdata, (i == 3));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if ({mem_ce, mem_we} !== 2'b00) begin
      errors++; $display("FAIL wait_idle: ce %b we %b want 00", mem_ce, mem_we);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs[3];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    do_reset();
    mem_auto = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_req = (i < 3);
      if_addr = (i < 3) ? addrs[i] : '0;
      @(negedge clk);
      checks++;
      if (if_gnt !== (i < 3)) begin
        errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, if_gnt, (i < 3));
      end
      if (i > 0) begin
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, mem_fn(addrs[i-1])}) begin
          errors++; $display("FAIL b2b_rdata[%0d]: got %b %h want 1 %h", i, if_rvalid, if_rdata, mem_fn(addrs[i-1]));
        end
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: rvalid %b want 0", if_rvalid);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    int seen;
    do_reset();
    mem_ready = 1'b0;
    d_req = 1'b1; d_addr = 32'h50;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL rmid_gnt: got %b want 1", d_gnt);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (mem_ce !== 1'b1) begin
      errors++; $display("FAIL rmid_active: ce %b want 1", mem_ce);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({dbg_state, mem_ce, mem_we, mem_addr} !== {IDLE, 2'b00, 32'h0}) begin
      errors++; $display("FAIL rmid_idle: state %0d ce %b we %b addr %h", dbg_state, mem_ce, mem_we, mem_addr);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (d_rvalid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rmid_rvalid: got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_withdraw();
    int seen_d;
    do_reset();
    mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL wd_if_gnt: got %b want 1", if_gnt);
    end
    step();
    if_req = 1'b0;
    d_req = 1'b1; d_addr = 32'h60;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b0) begin
      errors++; $display("FAIL wd_d_gnt: got %b want 0", d_gnt);
    end
    step();
    d_req = 1'b0;
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata, d_gnt} !== {1'b1, mem_fn(32'h300), 1'b0}) begin
      errors++; $display("FAIL wd_if_done: rvalid %b rdata %h d_gnt %b", if_rvalid, if_rdata, d_gnt);
    end
    step();
    seen_d = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_rvalid || mem_ce) seen_d++;
      step();
    end
    checks++;
    if (seen_d !== 0) begin
      errors++; $display("FAIL wd_no_access: got %0d active cycles want 0", seen_d);
    end
  endtask

  task automatic test_random();
    int            own;  // 0 free, 1 fetch, 2 data
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          own_we;
    logic          last_d, if_wins, free, exp_ifg, exp_dg, done;
    bit            if_pend, d_pend;
    logic [DW-1:0] exp_rd;
    exp_q.delete();
    do_reset();
    mem_auto = 1'b1;
    own = 0; own_addr = '0; own_wdata = '0; own_we = 1'b0;
    last_d = 1'b0; if_pend = 0; d_pend = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = $urandom_range(0, 1023) << 2;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_addr = $urandom_range(0, 1023) << 2;
        d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
      end
      if_req = if_pend;
      d_req = d_pend;
      mem_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      free = (own == 0) || mem_ready;
      done = (own != 0) && mem_ready;
`ifdef MEM_ARB_RR_EN
      if_wins = last_d;
`else
      if_wins = 1'b0;
`endif
      exp_ifg = free && if_req && (!d_req || if_wins);
      exp_dg  = free && d_req && !exp_ifg;
      checks++;
      if ({if_gnt, d_gnt} !== {exp_ifg, exp_dg}) begin
        errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", cyc, {if_gnt, d_gnt}, {exp_ifg, exp_dg});
      end
      checks++;
      if (mem_ce !== (own != 0)) begin
        errors++; $display("FAIL rnd_ce[%0d]: got %b want %b", cyc, mem_ce, (own != 0));
      end
      if (own != 0) begin
        checks++;
        if ({mem_addr, mem_we} !== {own_addr, own_we} || (own_we && mem_wdata !== own_wdata)) begin
          errors++; $display("FAIL rnd_mem[%0d]: addr %h we %b wdata %h want %h %b %h", cyc, mem_addr, mem_we, mem_wdata, own_addr, own_we, own_wdata);
        end
      end
      checks++;
      if ({if_rvalid, d_rvalid} !== {done && own == 1, done && own == 2}) begin
        errors++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", cyc, {if_rvalid, d_rvalid}, {done && own == 1, done && own == 2});
      end
      exp_rd = '0;
      if (done && exp_q.size() > 0) exp_rd = exp_q.pop_front();
      checks++;
      if (if_rdata !== ((done && own == 1) ? exp_rd : '0) || d_rdata !== ((done && own == 2) ? exp_rd : '0)) begin
        errors++; $display("FAIL rnd_rdata[%0d]: if %h d %h want %h for owner %0d", cyc, if_rdata, d_rdata, exp_rd, own);
      end
      if (done) own = 0;
      if (exp_ifg) begin
        own = 1; own_addr = if_addr; own_we = 1'b0; own_wdata = '0;
        exp_q.push_back(mem_fn(if_addr));
        if_pend = 0; last_d = 1'b0;
      end else if (exp_dg) begin
        own = 2; own_addr = d_addr; own_we = d_we; own_wdata = d_wdata;
        exp_q.push_back(d_we ? '0 : mem_fn(d_addr));
        d_pend = 0; last_d = 1'b1;
      end
      step();
    end
    idle_inputs();
    mem_ready = 1'b1;
    step();
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_auto = 1'b1;
    mem_rdata_man = '0;
    idle_inputs();
    test_reset();
    test_solo_fetch();
    test_conflict();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_access();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
